// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, opcode field position and fetch state encoding shared by the CPU blocks
package cpu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_SW  = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_e;

  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int opc_lsb(input int instr_w);
    return instr_w - 2;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO holding {addr, instr} pairs returned from instruction memory
module fetch_fifo #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   count_q;

  // pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == 2'd2;
  assign empty = count_q == 2'd0;

  push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: walks the PC through synchronous instruction memory and hands words to the decoder
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 32,
  parameter int RESET_PC   = 0,
  parameter int PROG_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [1:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               busy,
  output logic               done
);
  localparam int                MSB     = opc_msb(INSTR_W);
  localparam int                LSB     = opc_lsb(INSTR_W);
  localparam logic [ADDR_W-1:0] PC0     = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [ADDR_W:0]   LAST    = PROG_WORDS[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, ret_addr_q;
  logic [ADDR_W:0]     issued_q, issued_d;
  logic                inflight_q;
  logic                pop, full, empty;
  logic [1:0]          count;
  logic [2:0]          occ;
  logic [ADDR_W-1:0]   head_addr;
  logic [INSTR_W-1:0]  head_instr;

  // occ is what the FIFO plus the read in flight will hold once this cycle's pop is taken
  assign pop = if_valid & if_ready;
  assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};

  // next state, issue decision and PC/count updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    imem_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = FETCH;
          pc_d     = PC0;
          issued_d = '0;
        end
      end
      FETCH: begin
        imem_en = (occ < 3'd2) && (issued_q < LAST);
        if (imem_en) begin
          pc_d     = pc_q + PC_ONE;
          issued_d = issued_q + CNT_ONE;
        end
        if (issued_d == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (occ == 3'd0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, PC and the single outstanding read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= PC0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      ret_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      inflight_q <= imem_en;
      ret_addr_q <= pc_q;
    end
  end

  fetch_fifo #(.W(ADDR_W + INSTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .wdata ({ret_addr_q, imem_rdata}),
    .rdata ({head_addr, head_instr}),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr = pc_q;
  assign if_valid  = !empty;
  assign if_instr  = empty ? '0 : head_instr;
  assign if_pc     = empty ? PC0 : head_addr;
  assign if_opcode = if_instr[MSB:LSB];
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; instance 0 fetches 4 words, instance 1 fetches 6
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  if_ready = '0;
  logic [1:0]  imem_en, if_valid, busy, done;
  logic [7:0]  imem_addr [2];
  logic [7:0]  if_pc [2];
  logic [31:0] imem_rdata [2];
  logic [31:0] if_instr [2];
  logic [1:0]  if_opcode [2];
  logic [39:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(0), .PROG_WORDS(g == 0 ? 4 : 6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .imem_en    (imem_en[g]),
      .imem_addr  (imem_addr[g]),
      .imem_rdata (imem_rdata[g]),
      .if_valid   (if_valid[g]),
      .if_ready   (if_ready[g]),
      .if_instr   (if_instr[g]),
      .if_opcode  (if_opcode[g]),
      .if_pc      (if_pc[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a[1:0], 6'h2a, a ^ 8'h5c, ~a, a};
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (imem_en[k]) imem_rdata[k] <= mem_word(imem_addr[k]);

  task automatic push_prog(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), mem_word(8'(i))});
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({imem_en[k], if_valid[k], busy[k], done[k], imem_addr[k], if_pc[k], if_instr[k], if_opcode[k]} !== 54'd0) begin
        failures++;
        $display("FAIL reset_values dut%0d en=%b v=%b busy=%b done=%b addr=%h pc=%h instr=%h opc=%b exp all zero",
                 k, imem_en[k], if_valid[k], busy[k], done[k], imem_addr[k], if_pc[k], if_instr[k], if_opcode[k]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({imem_en[k], if_valid[k], busy[k], done[k]} !== 4'b0) begin
          failures++;
          $display("FAIL idle dut%0d en/v/busy/done=%b exp 0000", k, {imem_en[k], if_valid[k], busy[k], done[k]});
        end
      end
    end
  endtask

  task automatic test_basic;
    logic [39:0] e;
    push_prog(4);
    if_ready[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (imem_en[0] !== (c >= 1 && c <= 4)) begin
        failures++;
        $display("FAIL basic_en cycle %0d got %b", c, imem_en[0]);
      end
      if (imem_en[0]) begin
        checks++;
        if (imem_addr[0] !== 8'(c - 1)) begin
          failures++;
          $display("FAIL basic_addr cycle %0d got %0d exp %0d", c, imem_addr[0], c - 1);
        end
      end
      checks++;
      if (if_valid[0] !== (c >= 3 && c <= 6) || busy[0] !== (c >= 1 && c <= 6) || done[0] !== (c >= 7)) begin
        failures++;
        $display("FAIL basic_flags cycle %0d valid=%b busy=%b done=%b", c, if_valid[0], busy[0], done[0]);
      end
      if (if_valid[0]) begin
        checks++;
        if (if_opcode[0] !== 2'(c - 3)) begin
          failures++;
          $display("FAIL basic_opcode cycle %0d got %b exp %b", c, if_opcode[0], 2'(c - 3));
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL basic_extra pc=%0d", if_pc[0]);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc[0], if_instr[0]} !== e) begin
            failures++;
            $display("FAIL basic_data got %h exp %h", {if_pc[0], if_instr[0]}, e);
          end
        end
      end
      @(posedge clk);
      #1 start[0] = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_missing got %0d left exp 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [39:0] e;
    logic        hs;
    int          issued = 0, got = 0;
    push_prog(4);
    @(posedge clk);
    #1 start[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if_ready[0] = !(c >= 4 && c <= 7);
      @(negedge clk);
      if (c >= 4 && c <= 7) begin
        checks++;
        if (if_valid[0] !== 1'b1 || if_pc[0] !== 8'd1 || if_instr[0] !== mem_word(8'd1)) begin
          failures++;
          $display("FAIL bp_hold cycle %0d valid=%b pc=%0d instr=%h exp pc 1", c, if_valid[0], if_pc[0], if_instr[0]);
        end
      end
      if (c >= 5 && c <= 7) begin
        checks++;
        if (imem_en[0] !== 1'b0) begin
          failures++;
          $display("FAIL bp_en cycle %0d got %b exp 0", c, imem_en[0]);
        end
      end
      hs = if_valid[0] & if_ready[0];
      checks++;
      if (issued - got + int'(imem_en[0]) - int'(hs) > 2) begin
        failures++;
        $display("FAIL bp_outstanding cycle %0d got %0d exp <=2", c, issued - got + int'(imem_en[0]) - int'(hs));
      end
      issued += int'(imem_en[0]);
      got += int'(hs);
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra pc=%0d", if_pc[0]);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc[0], if_instr[0]} !== e) begin
            failures++;
            $display("FAIL bp_data got %h exp %h", {if_pc[0], if_instr[0]}, e);
          end
        end
      end
      @(posedge clk);
      #1 start[0] = 1'b0;
      if (done[0]) break;
    end
    if_ready[0] = 1'b1;
    checks++;
    if (done[0] !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_end done=%b left=%0d exp done 1 left 0", done[0], exp_q.size());
    end
  endtask

  task automatic test_alternating;
    logic [39:0] e;
    logic        hs;
    int          issued = 0, got = 0;
    push_prog(6);
    @(posedge clk);
    #1 start[1] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if_ready[1] = (c % 2 == 0);
      @(negedge clk);
      hs = if_valid[1] & if_ready[1];
      checks++;
      if (issued - got + int'(imem_en[1]) - int'(hs) > 2) begin
        failures++;
        $display("FAIL alt_outstanding cycle %0d got %0d exp <=2", c, issued - got + int'(imem_en[1]) - int'(hs));
      end
      issued += int'(imem_en[1]);
      got += int'(hs);
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL alt_extra pc=%0d", if_pc[1]);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc[1], if_instr[1]} !== e) begin
            failures++;
            $display("FAIL alt_data got %h exp %h", {if_pc[1], if_instr[1]}, e);
          end
        end
      end
      @(posedge clk);
      #1 start[1] = 1'b0;
      if (done[1]) break;
    end
    checks++;
    if (got != 6 || issued != 6 || done[1] !== 1'b1) begin
      failures++;
      $display("FAIL alt_count handshakes=%0d issues=%0d done=%b exp 6 6 1", got, issued, done[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [39:0] e;
    logic        hs;
    logic        first = 1'b1;
    if_ready[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        checks++;
        if (imem_en[0] !== 1'b1) begin
          failures++;
          $display("FAIL rm_en cycle %0d got %b exp 1", c, imem_en[0]);
        end
      end
      @(posedge clk);
      #1 start[0] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (if_valid[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        failures++;
        $display("FAIL rm_after cycle %0d valid=%b busy=%b done=%b exp 0 0 0", c, if_valid[0], busy[0], done[0]);
      end
    end
    push_prog(4);
    @(posedge clk);
    #1 start[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (imem_en[0] && first) begin
        first = 1'b0;
        checks++;
        if (imem_addr[0] !== 8'd0) begin
          failures++;
          $display("FAIL rm_restart_addr got %0d exp 0", imem_addr[0]);
        end
      end
      hs = if_valid[0] & if_ready[0];
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rm_extra pc=%0d", if_pc[0]);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc[0], if_instr[0]} !== e) begin
            failures++;
            $display("FAIL rm_data got %h exp %h", {if_pc[0], if_instr[0]}, e);
          end
        end
      end
      @(posedge clk);
      #1 start[0] = 1'b0;
      if (done[0]) break;
    end
    checks++;
    if (done[0] !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rm_end done=%b left=%0d exp done 1 left 0", done[0], exp_q.size());
    end
  endtask

  task automatic test_start_ignored;
    logic [39:0] e;
    logic        hs;
    logic [7:0]  next_addr;
    int          issued;
    if_ready[0] = 1'b1;
    for (int run = 0; run < 2; run++) begin
      push_prog(4);
      next_addr = 8'd0;
      issued = 0;
      if (run == 1) begin
        checks++;
        if (done[0] !== 1'b1) begin
          failures++;
          $display("FAIL si_done_before got %b exp 1", done[0]);
        end
      end
      @(posedge clk);
      #1 start[0] = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (c == 2) start[0] = 1'b1;
        @(negedge clk);
        if (c == 1) begin
          checks++;
          if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL si_started run %0d busy=%b done=%b exp 1 0", run, busy[0], done[0]);
          end
        end
        if (imem_en[0]) begin
          checks++;
          if (imem_addr[0] !== next_addr) begin
            failures++;
            $display("FAIL si_addr run %0d got %0d exp %0d", run, imem_addr[0], next_addr);
          end
          next_addr++;
          issued++;
        end
        hs = if_valid[0] & if_ready[0];
        if (hs) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL si_extra pc=%0d", if_pc[0]);
          end else begin
            e = exp_q.pop_front();
            if ({if_pc[0], if_instr[0]} !== e) begin
              failures++;
              $display("FAIL si_data got %h exp %h", {if_pc[0], if_instr[0]}, e);
            end
          end
        end
        @(posedge clk);
        #1 start[0] = 1'b0;
        if (done[0]) break;
      end
      checks++;
      if (done[0] !== 1'b1 || exp_q.size() != 0 || issued != 4) begin
        failures++;
        $display("FAIL si_end run %0d done=%b left=%0d issues=%0d exp 1 0 4", run, done[0], exp_q.size(), issued);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_alternating();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
